edge_detect: RTL and testbench

- Synchronous edge detector for a WIDTH-bit bundle of single-bit level signals (default one bit).
- Samples each input bit every clock and compares it with the previous sample.
- Emits one-cycle registered pulses on rising, falling or any edge, selected at run time.
- Keeps a saturating per-block edge counter for debug/status.
- Sits between level-type control/status signals and the pulse-driven logic that consumes them.

---
 rtl/edge_detect.sv | 114 +++++++++++
 tb/tb_edge_detect.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect.sv
// Per-bit rising/falling/any edge detector with one-cycle registered pulses and a saturating edge counter.
// Define EDGE_DETECT_SYNC_EN to put a two-flop synchroniser in front of the detector for asynchronous i_a.
module edge_detect #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic [1:0]       i_mode,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_out,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_any,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] w_a;
  logic             w_src_ok;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_out;
  logic             w_any;

  logic [WIDTH-1:0] r_prev;
  logic             r_armed;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_any;
  logic [CNT_W-1:0] r_count;

`ifdef EDGE_DETECT_SYNC_EN
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [1:0]       r_fill;

  // Arming is held off until both synchroniser stages carry post-reset samples.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_fill  <= 2'd0;
    end else begin
      r_sync1 <= i_a;
      r_sync2 <= r_sync1;
      if (r_fill != 2'd2) begin
        r_fill <= r_fill + 2'd1;
      end
    end
  end

  assign w_a      = r_sync2;
  assign w_src_ok = (r_fill == 2'd2);
`else
  assign w_a      = i_a;
  assign w_src_ok = 1'b1;
`endif

  always_comb begin
    w_rise = '0;
    w_fall = '0;
    w_out  = '0;
    if (r_armed) begin
      w_rise = w_a & ~r_prev;
      w_fall = ~w_a & r_prev;
    end
    case (i_mode)
      2'b00:   w_out = w_rise;
      2'b01:   w_out = w_fall;
      2'b10:   w_out = w_rise | w_fall;
      default: w_out = '0;
    endcase
    w_any = |w_out;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_prev  <= '0;
      r_armed <= 1'b0;
      r_out   <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_any   <= 1'b0;
      r_count <= '0;
    end else begin
      // The first valid clock only captures the input; no edge is reported for it.
      if (w_src_ok) begin
        r_prev  <= w_a;
        r_armed <= 1'b1;
      end
      r_out  <= w_out;
      r_rise <= w_rise;
      r_fall <= w_fall;
      r_any  <= w_any;
      if (i_clr) begin
        r_count <= '0;
      end else if (w_any && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNT_ONE;
      end
    end
  end

  assign o_out   = r_out;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_any   = r_any;
  assign o_count = r_count;

endmodule

// File: tb/tb_edge_detect.sv
// Directed bench for edge_detect (WIDTH=2, CNT_W=4) with a queue-based reference model checked every cycle.
module tb_edge_detect;

  localparam int W   = 2;
  localparam int CW  = 4;
  localparam int MAXC = (1 << CW) - 1;
`ifdef EDGE_DETECT_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  a;
  logic [1:0]    mode;
  logic          clr;
  logic [W-1:0]  o_out, o_rise, o_fall;
  logic          o_any;
  logic [CW-1:0] o_count;

  int checks = 0;
  int errors = 0;

  edge_detect #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .i_a    (a),
    .i_mode (mode),
    .i_clr  (clr),
    .o_out  (o_out),
    .o_rise (o_rise),
    .o_fall (o_fall),
    .o_any  (o_any),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  // Reference model: history of sampled inputs since reset release.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_rise, m_fall, m_out;
  int           m_raw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      m_rise = '0;
      m_fall = '0;
      m_out  = '0;
      m_raw  = 0;
    end else begin
      logic [W-1:0] cur, prv;
      hist.push_back(a);
      if (hist.size() > D + 2) void'(hist.pop_front());
      m_rise = '0;
      m_fall = '0;
      if (hist.size() >= D + 2) begin
        cur = hist[hist.size() - 1 - D];
        prv = hist[hist.size() - 2 - D];
        m_rise = cur & ~prv;
        m_fall = ~cur & prv;
      end
      if (mode == 2'b00)      m_out = m_rise;
      else if (mode == 2'b01) m_out = m_fall;
      else if (mode == 2'b10) m_out = m_rise | m_fall;
      else                    m_out = '0;
      if (clr)             m_raw = 0;
      else if (|m_out)     m_raw = m_raw + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  bit run_cmp = 1'b0;

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("model.out",   32'(o_out),   32'(m_out));
      chk("model.rise",  32'(o_rise),  32'(m_rise));
      chk("model.fall",  32'(o_fall),  32'(m_fall));
      chk("model.any",   32'(o_any),   32'(|m_out));
      chk("model.count", 32'(o_count), (m_raw > MAXC) ? MAXC : m_raw);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    a     = '0;
    mode  = 2'b00;
    clr   = 1'b0;
    repeat (3) tick();
    run_cmp = 1'b1;
    chk("reset.out",   32'(o_out),   0);
    chk("reset.count", 32'(o_count), 0);

    // Release with inputs already high: no spurious rise.
    a = 2'b11;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hi_release.rise", 32'(o_rise), 0);
      chk("hi_release.out",  32'(o_out),  0);
    end
    chk("hi_release.count", 32'(o_count), 0);

    // Mode 00: single rise then fall on bit 0.
    a = 2'b00;
    repeat (2) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    a = 2'b01; tick();
    chk("m00.rise_out",  32'(o_out),  32'h1);
    chk("m00.rise_rise", 32'(o_rise), 32'h1);
    repeat (3) tick();
    chk("m00.hold_out", 32'(o_out), 0);
    a = 2'b00; tick();
    chk("m00.fall_fall", 32'(o_fall), 32'h1);
    chk("m00.fall_out",  32'(o_out),  0);
    chk("m00.count",     32'(o_count), 1);

    // Mode 10: toggle every cycle, output stays high.
    mode = 2'b10;
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a[0] = ~a[0];
      tick();
      chk("m10.out", 32'(o_out[0]), 1);
      chk("m10.alt", 32'(o_rise[0]), 32'(a[0]));
    end
    chk("m10.count", 32'(o_count), 8);

    // Mode 11: disabled, but raw rise/fall still tracked by the model.
    mode = 2'b11;
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom_range(0, 3));
      tick();
      chk("m11.any", 32'(o_any), 0);
    end
    chk("m11.count", 32'(o_count), 8);

    // Mode changes alone never create pulses.
    a = 2'b00; tick();
    mode = 2'b00; tick();
    mode = 2'b01; tick();
    chk("modechg.out", 32'(o_out), 0);
    a = 2'b10; tick();
    a = 2'b00; tick();
    chk("m01.fall_out", 32'(o_out), 32'h2);

    // Saturation and clear priority.
    mode = 2'b10;
    for (int i = 0; i < 20; i++) begin
      a[0] = ~a[0];
      tick();
    end
    chk("sat.count", 32'(o_count), MAXC);
    clr = 1'b1; a[0] = ~a[0]; tick();
    chk("clr.count", 32'(o_count), 0);
    clr = 1'b0; a[0] = ~a[0]; tick();
    chk("clr_next.count", 32'(o_count), 1);

    // Asynchronous reset mid-pulse.
    a[0] = ~a[0];
    @(posedge clk); #2;
    chk("midrst.pre_out", 32'(o_out[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.out",   32'(o_out),   0);
    chk("midrst.count", 32'(o_count), 0);
    a = 2'b11;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rearm.out",  32'(o_out),  0);
    chk("rearm.rise", 32'(o_rise), 0);
    repeat (2 * D) tick();
    tick();
    chk("rearm2.out", 32'(o_out), 0);
    a = 2'b01;
    repeat (D + 1) tick();
    chk("rearm.fall_out", 32'(o_out),   32'h2);
    chk("rearm.count",    32'(o_count), 1);
    repeat (2) tick();

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
